// File: rtl/cpu_pkg.sv
// Shared decode-stage types: field widths, class codes, opcode ranges, FSM states.
// No ports; imported by op_classify and cmd_decoder.
package cpu_pkg;

    localparam int DATA_W = 14;
    localparam int REG_W  = 4;
    localparam int OPC_W  = DATA_W - 2*REG_W;

    // Last opcode of each class range; opcode 0 is NOP, BRANCH runs to NUM_OPS-1
    localparam int ALU_LAST = 15;
    localparam int MEM_LAST = 19;

    typedef enum logic [1:0] {
        CLS_NOP = 2'd0,
        CLS_ALU = 2'd1,
        CLS_MEM = 2'd2,
        CLS_BR  = 2'd3
    } cls_e;

    typedef enum logic [2:0] {
        FETCH,
        CHECK,
        DECODE,
        ISSUE,
        HALT
    } state_e;

    // Field layout of one pair: word0 = {opcode, rd, rs}, word1 = imm
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs;
        logic [DATA_W-1:0] imm;
    } fields_t;

    function automatic fields_t split_pair(input logic [2*DATA_W-1:0] p);
        return fields_t'(p);
    endfunction

endpackage

// File: rtl/cmd_decoder_op_classify.sv
// Combinational opcode classifier, shared by decode and execute.
// Ports: opcode_i in; cls_o class code, illegal_o opcode >= NUM_OPS.
module op_classify
    import cpu_pkg::*;
#(
    parameter int NUM_OPS = 24
) (
    input  logic [OPC_W-1:0] opcode_i,
    output cls_e             cls_o,
    output logic             illegal_o
);

    always_comb begin
        cls_o     = CLS_NOP;
        illegal_o = 1'b0;
        if (opcode_i >= OPC_W'(NUM_OPS)) begin
            illegal_o = 1'b1;
        end else if (opcode_i == '0) begin
            cls_o = CLS_NOP;
        end else if (opcode_i <= OPC_W'(ALU_LAST)) begin
            cls_o = CLS_ALU;
        end else if (opcode_i <= OPC_W'(MEM_LAST)) begin
            cls_o = CLS_MEM;
        end else begin
            cls_o = CLS_BR;
        end
    end

endmodule

// File: rtl/cmd_decoder.sv
// Decode stage: pulls command pairs from the buffer, splits and classifies them,
// and issues one instruction at a time to execute over dec_valid/exec_ready.
// Ports: clk, reset (async high); command_out/pause_DECODE/comm_read buffer side;
// dec_valid/exec_ready, opcode/rd/rs/imm/cls/illegal_op execute side; decoded_cnt.
// Build option: DECODER_ILLEGAL_TRAP_EN traps illegal opcodes into HALT;
// without it illegal opcodes issue as NOP and illegal_op is tied low.
module cmd_decoder
    import cpu_pkg::*;
#(
    parameter int NUM_OPS = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*DATA_W-1:0] command_out,
    input  logic                pause_DECODE,
    output logic                comm_read,
    output logic                dec_valid,
    input  logic                exec_ready,
    output logic [OPC_W-1:0]    opcode,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    rs,
    output logic [DATA_W-1:0]   imm,
    output logic [1:0]          cls,
    output logic                illegal_op,
    output logic [15:0]         decoded_cnt
);

    state_e              state_q, state_d;
    logic [2*DATA_W-1:0] pair_q;
    logic [OPC_W-1:0]    opcode_q;
    logic [REG_W-1:0]    rd_q, rs_q;
    logic [DATA_W-1:0]   imm_q;
    cls_e                cls_q;
    logic [15:0]         cnt_q;

    fields_t f;
    cls_e    dec_cls;
    logic    dec_ill;

    assign f = split_pair(pair_q);

    op_classify #(
        .NUM_OPS (NUM_OPS)
    ) u_classify (
        .opcode_i  (f.opcode),
        .cls_o     (dec_cls),
        .illegal_o (dec_ill)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:  state_d = CHECK;
            CHECK:  state_d = pause_DECODE ? FETCH : DECODE;
`ifdef DECODER_ILLEGAL_TRAP_EN
            DECODE: state_d = dec_ill ? HALT : ISSUE;
`else
            DECODE: state_d = ISSUE;
`endif
            ISSUE:  if (exec_ready) state_d = FETCH;
            HALT:   state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // comm_read is gated by reset so it stays low while reset holds FETCH
    always_comb begin
        comm_read = (state_q == FETCH) && !reset;
        dec_valid = (state_q == ISSUE);
    end

    // The buffer answers on the negedge inside CHECK, so capture there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_q <= '0;
        end else if (state_q == CHECK && !pause_DECODE) begin
            pair_q <= command_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            imm_q    <= '0;
            cls_q    <= CLS_NOP;
        end else if (state_q == DECODE) begin
            rd_q  <= f.rd;
            rs_q  <= f.rs;
            imm_q <= f.imm;
            cls_q <= dec_cls;
`ifdef DECODER_ILLEGAL_TRAP_EN
            opcode_q <= f.opcode;
`else
            // Illegal opcodes go out as NOP (classifier already yields CLS_NOP)
            opcode_q <= dec_ill ? '0 : f.opcode;
`endif
        end
    end

`ifdef DECODER_ILLEGAL_TRAP_EN
    logic ill_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ill_q <= 1'b0;
        end else if (state_q == DECODE && dec_ill) begin
            ill_q <= 1'b1;
        end
    end

    assign illegal_op = ill_q;
`else
    assign illegal_op = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (dec_valid && exec_ready) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign opcode      = opcode_q;
    assign rd          = rd_q;
    assign rs          = rs_q;
    assign imm         = imm_q;
    assign cls         = cls_q;
    assign decoded_cnt = cnt_q;

endmodule

// File: doc/cmd_decoder.md
Name: cmd_decoder

Overview:
- Decode stage directly downstream of the command buffer.
- Pulls 28-bit command pairs from the buffer over the comm_read / pause_DECODE handshake.
- Splits each pair into opcode, register and immediate fields, classifies the opcode, and presents one decoded instruction to the execute stage under a valid/ready handshake.
- Single clock; all registers update on posedge clk.

Parameters:
- DATA_W, 14, width of one command word; pair width is 2*DATA_W.
- REG_W, 4, register index width; opcode width OPC_W = DATA_W-2*REG_W = 6.
- NUM_OPS, 24, number of defined opcodes (0..NUM_OPS-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- command_out  in  2*DATA_W  command pair from buffer; word0 = [27:14], word1 = [13:0].
- pause_DECODE  in  1  buffer stall flag; 1 = no pair delivered.
- comm_read  out  1  read request to buffer.
- dec_valid  out  1  decoded instruction valid.
- exec_ready  in  1  execute stage accepts when dec_valid & exec_ready.
- opcode  out  OPC_W  word0[13:8].
- rd  out  REG_W  word0[7:4].
- rs  out  REG_W  word0[3:0].
- imm  out  DATA_W  word1.
- cls  out  2  class: 0 = NOP, 1 = ALU, 2 = MEM, 3 = BRANCH.
- illegal_op  out  1  illegal opcode flag (see Optional Feature).
- decoded_cnt  out  16  count of issued instructions.

Behaviour:
- Reset (async, active-high) forces: state=FETCH, comm_read=0, dec_valid=0, opcode/rd/rs/imm=0, cls=0, illegal_op=0, decoded_cnt=0. Reset mid-ISSUE drops the held instruction; nothing is issued.
- States and transitions:
  - FETCH: comm_read=1 for exactly one cycle, then go to CHECK.
  - CHECK: comm_read=0. The buffer answers on the intervening negedge, so pause_DECODE is sampled here.
    - pause_DECODE=1: go to FETCH (retry; minimum 2-cycle retry loop).
    - pause_DECODE=0: latch command_out into a pair register, go to DECODE.
  - DECODE: register the field splits and the class; go to ISSUE.
  - ISSUE: dec_valid=1; all outputs held stable while exec_ready=0.
    - On dec_valid & exec_ready: increment decoded_cnt (mod 2^16, wraps 0xFFFF->0), go to FETCH. dec_valid falls the next cycle.
- Latency: from the FETCH cycle to dec_valid is 3 cycles with no stall. Best-case throughput is one instruction per 4 cycles.
- Classification by opcode:
  - 0 -> NOP.
  - 1..15 -> ALU.
  - 16..19 -> MEM.
  - 20..NUM_OPS-1 -> BRANCH.
  - >= NUM_OPS -> illegal.
- comm_read is never asserted outside FETCH, so at most one pair is outstanding.
- exec_ready asserted outside ISSUE is ignored.

Optional Feature:
- Macro DECODER_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE sets illegal_op=1 and moves to state HALT.
  - HALT: comm_read=0, dec_valid=0, outputs frozen, left only via reset. decoded_cnt is not incremented.
- Not defined: an illegal opcode is issued as a NOP. opcode output = 0, cls=0, rd/rs/imm passed through. illegal_op is tied to 0.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, REG_W and OPC_W constants.
  - Class encodings CLS_NOP, CLS_ALU, CLS_MEM, CLS_BR.
  - Opcode range boundaries (ALU_LAST=15, MEM_LAST=19).
  - FSM state enum (FETCH, CHECK, DECODE, ISSUE, HALT).
- One sub-module, op_classify: purely combinational opcode -> {cls, illegal}, reused later by execute.

Test Plan:
- After reset, pause_DECODE=0, command_out={14'h0325,14'h1ABC}, exec_ready=1 -> comm_read pulses at cycle 0; at cycle 3 dec_valid=1 with opcode=3, rd=2, rs=5, imm=0x1ABC, cls=1; decoded_cnt=1 after the handshake.
- pause_DECODE=1 for 3 checks, then 0 -> comm_read pulses every 2 cycles 4 times; exactly one instruction issued.
- exec_ready=0 for 5 cycles during ISSUE with opcode=0x12 -> dec_valid held, outputs stable, cls=2; accepted on the cycle exec_ready=1.
- Opcode 0x3F with DECODER_ILLEGAL_TRAP_EN -> illegal_op=1, no dec_valid, no further comm_read until reset. Without the macro -> dec_valid=1, opcode=0, cls=0, illegal_op=0.
- Reset asserted asynchronously mid-ISSUE -> dec_valid=0 immediately; decoded_cnt=0; FETCH resumes after release.
- Preload decoded_cnt path with 65536 issues -> counter wraps to 0.
